// File: rtl/adder4_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adder4_share_ctrl (with helper adder_4bit)
// Purpose  : Shares one 4-bit adder between two requesters. Each accepted
//            operation adds WIDTH-bit operands nibble-serially, least
//            significant nibble first, carrying through a register. The two
//            requesters are arbitrated round-robin. Valid/ready handshakes
//            are used on both the request and the response side.
// Ports    : clk, rst                 - clock (rising edge), async active-high reset
//            reqN_valid/ready         - request handshake, N = 0, 1
//            reqN_a, reqN_b, reqN_cin - operands and carry-in
//            reqN_sub                 - subtract select (ADD_SUB_EN builds only)
//            rsp_valid/ready          - response handshake
//            rsp_id                   - index of the requester that owns the result
//            rsp_sum, rsp_cout        - sum modulo 2^WIDTH and carry out
//            busy                     - high while an operation is in flight
// Options  : ADD_SUB_EN - when defined, adds reqN_sub ports. sub=1 computes
//            A-B, and rsp_cout=1 then means "no borrow".
// Revision : 1.0 - initial release
// ============================================================================

module adder_4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};
endmodule

module adder4_share_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
`ifdef ADD_SUB_EN
    input  logic             req0_sub,
`endif
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
`ifdef ADD_SUB_EN
    input  logic             req1_sub,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             busy
);
    localparam int NIBS  = WIDTH / 4;
    localparam int CNT_W = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             id_q, id_d;
    logic             valid_q, valid_d;
    logic             last_grant_q, last_grant_d;
`ifdef ADD_SUB_EN
    logic             sub_q, sub_d;
`endif

    logic             grant0, grant1;
    logic [3:0]       a_nib, b_nib, b_in, nib_sum;
    logic             nib_cout;

    // Round-robin: on a tie the requester that was not granted last wins.
    // Reset leaves last_grant at 1 so requester 0 wins the first tie.
    always_comb begin
        grant0 = (state_q == IDLE) && req0_valid && (!req1_valid || last_grant_q);
        grant1 = (state_q == IDLE) && req1_valid && (!req0_valid || !last_grant_q);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Select the operand nibbles that the counter points at.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBS; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
`ifdef ADD_SUB_EN
        // Two's-complement subtract: invert B. The initial carry of 1 is
        // loaded at accept.
        b_in = sub_q ? ~b_nib : b_nib;
`else
        b_in = b_nib;
`endif
    end

    adder_4bit u_adder (
        .i_a    (a_nib),
        .i_b    (b_in),
        .i_cin  (carry_q),
        .o_sum  (nib_sum),
        .o_cout (nib_cout)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        carry_d      = carry_q;
        a_d          = a_q;
        b_d          = b_q;
        sum_d        = sum_q;
        cout_d       = cout_q;
        id_d         = id_q;
        valid_d      = valid_q;
        last_grant_d = last_grant_q;
`ifdef ADD_SUB_EN
        sub_d        = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    id_d         = grant1;
                    last_grant_d = grant1;
                    a_d          = grant1 ? req1_a : req0_a;
                    b_d          = grant1 ? req1_b : req0_b;
                    cnt_d        = '0;
`ifdef ADD_SUB_EN
                    sub_d        = grant1 ? req1_sub : req0_sub;
                    carry_d      = (grant1 ? req1_sub : req0_sub) ? 1'b1
                                 : (grant1 ? req1_cin : req0_cin);
`else
                    carry_d      = grant1 ? req1_cin : req0_cin;
`endif
                    state_d      = CALC;
                end
            end
            CALC: begin
                for (int i = 0; i < NIBS; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        sum_d[4*i +: 4] = nib_sum;
                    end
                end
                carry_d = nib_cout;
                if (cnt_q == LAST_NIB) begin
                    cnt_d   = '0;
                    cout_d  = nib_cout;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            carry_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            cout_q       <= 1'b0;
            id_q         <= 1'b0;
            valid_q      <= 1'b0;
            last_grant_q <= 1'b1;
`ifdef ADD_SUB_EN
            sub_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            carry_q      <= carry_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sum_q        <= sum_d;
            cout_q       <= cout_d;
            id_q         <= id_d;
            valid_q      <= valid_d;
            last_grant_q <= last_grant_d;
`ifdef ADD_SUB_EN
            sub_q        <= sub_d;
`endif
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adder4_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder4_share_ctrl
// Purpose  : Self-checking bench for adder4_share_ctrl (WIDTH=16). Results are
//            compared against a plain-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder4_share_ctrl;
    localparam int WIDTH = 16;
    localparam int NIBS  = WIDTH / 4;

    logic             clk;
    logic             rst;
    logic             req0_valid, req0_ready, req0_cin;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic             req1_valid, req1_ready, req1_cin;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic             req0_sub, req1_sub;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
    logic [WIDTH-1:0] rsp_sum;

    int n_checks = 0;
    int n_fail   = 0;

    adder4_share_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
`ifdef ADD_SUB_EN
        .req0_sub   (req0_sub),
`endif
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
`ifdef ADD_SUB_EN
        .req1_sub   (req1_sub),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {cout, sum} of A+B+cin, or A-B with cout = "no borrow".
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic cin, input logic sub);
        logic [WIDTH-1:0] d;
        if (sub) begin
            d = a - b;
            return {(a >= b), d};
        end
        return {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    endfunction

    task automatic apply_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issues one request, waits (bounded) for the response and returns it.
    // With rsp_ready high the response handshake is completed before return.
    task automatic run_op(input logic id, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic cin,
                          input logic sub,
                          output logic [WIDTH-1:0] s, output logic co,
                          output logic rid, output int lat, output logic to);
        int wait_n;
        s = '0; co = 1'b0; rid = 1'b0; lat = 0; to = 1'b0;
        @(negedge clk);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin; req1_sub = sub;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin; req0_sub = sub;
        end
        #1;
        wait_n = 0;
        while (!(id ? req1_ready : req0_ready) && wait_n < 20) begin
            @(negedge clk); #1;
            wait_n++;
        end
        if (wait_n >= 20) begin
            to = 1'b1;
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        // Operands change after the accept edge; the result must not follow.
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom); req0_cin = 1'($urandom);
        req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom); req1_cin = 1'($urandom);
        req0_sub = 1'($urandom); req1_sub = 1'($urandom);
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) begin
            to = 1'b1;
            return;
        end
        s = rsp_sum; co = rsp_cout; rid = rsp_id;
        if (rsp_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        apply_reset();
        n_checks++;
        if ({rsp_valid, busy, rsp_id, rsp_cout} !== 4'b0000 || rsp_sum !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b busy=%b id=%b cout=%b sum=%h, required all 0",
                     rsp_valid, busy, rsp_id, rsp_cout, rsp_sum);
        end
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ready_idle: ready0=%b ready1=%b, required 0 0", req0_ready, req1_ready);
        end
        // First tie goes to requester 0; valids drop before the next edge.
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_first_tie: ready0=%b ready1=%b, required 1 0", req0_ready, req1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL ready_no_valid: ready0=%b ready1=%b, required 0 0", req0_ready, req1_ready);
        end
    endtask

    task automatic test_directed;
        logic [WIDTH-1:0] va[3] = '{16'h0001, 16'hFFFF, 16'h7FFF};
        logic [WIDTH-1:0] vb[3] = '{16'h0002, 16'h0001, 16'h0000};
        logic             vc[3] = '{1'b0, 1'b0, 1'b1};
        logic             vi[3] = '{1'b0, 1'b1, 1'b0};
        logic [WIDTH-1:0] s;
        logic [WIDTH:0]   exp;
        logic co, rid, to;
        int lat;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_op(vi[k], va[k], vb[k], vc[k], 1'b0, s, co, rid, lat, to);
            exp = model(va[k], vb[k], vc[k], 1'b0);
            n_checks++;
            if (to || s !== exp[WIDTH-1:0] || co !== exp[WIDTH] || rid !== vi[k] || lat != NIBS) begin
                n_fail++;
                $display("FAIL directed_%0d: timeout=%b sum=%h cout=%b id=%b lat=%0d, required sum=%h cout=%b id=%b lat=%0d",
                         k, to, s, co, rid, lat, exp[WIDTH-1:0], exp[WIDTH], vi[k], NIBS);
            end
        end
    endtask

    task automatic test_round_robin;
        logic [WIDTH:0] exp0, exp1, exp;
        logic exp_id;
        int nresp;
        apply_reset();
        rsp_ready = 1'b1;
        @(negedge clk);
        req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom); req0_cin = 1'b1; req0_sub = 1'b0;
        req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom); req1_cin = 1'b0; req1_sub = 1'b0;
        exp0 = model(req0_a, req0_b, 1'b1, 1'b0);
        exp1 = model(req1_a, req1_b, 1'b0, 1'b0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        exp_id = 1'b0;
        nresp = 0;
        for (int c = 0; c < 4*(NIBS+2) + 4; c++) begin
            @(negedge clk); #1;
            n_checks++;
            if (req0_ready && req1_ready) begin
                n_fail++;
                $display("FAIL rr_one_ready: ready0=%b ready1=%b, required at most one high",
                         req0_ready, req1_ready);
            end
            if (rsp_valid) begin
                exp = exp_id ? exp1 : exp0;
                n_checks++;
                if (rsp_id !== exp_id || rsp_sum !== exp[WIDTH-1:0] || rsp_cout !== exp[WIDTH]) begin
                    n_fail++;
                    $display("FAIL rr_response_%0d: id=%b sum=%h cout=%b, required id=%b sum=%h cout=%b",
                             nresp, rsp_id, rsp_sum, rsp_cout, exp_id, exp[WIDTH-1:0], exp[WIDTH]);
                end
                exp_id = ~exp_id;
                nresp++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_checks++;
        if (nresp < 4) begin
            n_fail++;
            $display("FAIL rr_count: responses=%0d, required >= 4", nresp);
        end
        repeat (NIBS + 3) @(posedge clk);
    endtask

    task automatic test_backpressure;
        logic [WIDTH-1:0] s;
        logic [WIDTH:0] exp;
        logic co, rid, to;
        int lat;
        rsp_ready = 1'b0;
        run_op(1'b1, 16'h0F0F, 16'h1234, 1'b1, 1'b0, s, co, rid, lat, to);
        exp = model(16'h0F0F, 16'h1234, 1'b1, 1'b0);
        n_checks++;
        if (to || s !== exp[WIDTH-1:0] || co !== exp[WIDTH] || rid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_result: timeout=%b sum=%h cout=%b id=%b, required sum=%h cout=%b id=1",
                     to, s, co, rid, exp[WIDTH-1:0], exp[WIDTH]);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_sum !== exp[WIDTH-1:0] || rsp_id !== 1'b1 ||
                rsp_cout !== exp[WIDTH] || busy !== 1'b1 || req0_ready || req1_ready) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: valid=%b sum=%h id=%b cout=%b busy=%b rdy=%b%b, required 1 %h 1 %b 1 00",
                         c, rsp_valid, rsp_sum, rsp_id, rsp_cout, busy, req0_ready, req1_ready,
                         exp[WIDTH-1:0], exp[WIDTH]);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b busy=%b, required 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_reset_mid;
        logic [WIDTH-1:0] s;
        logic co, rid, to, seen;
        int lat;
        rsp_ready = 1'b1;
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 16'hAAAA; req1_b = 16'h5555; req1_cin = 1'b1; req1_sub = 1'b0;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(posedge clk); #2;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: busy=%b, required 1", busy);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_sum !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_now: busy=%b valid=%b sum=%h, required 0 0 0000", busy, rsp_valid, rsp_sum);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (NIBS + 3) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL mid_no_response: rsp_valid seen=%b, required 0", seen);
        end
        run_op(1'b0, 16'h1234, 16'h1111, 1'b0, 1'b0, s, co, rid, lat, to);
        n_checks++;
        if (to || s !== 16'h2345 || co !== 1'b0 || rid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_next_op: timeout=%b sum=%h cout=%b id=%b, required 2345 0 0", to, s, co, rid);
        end
    endtask

    task automatic test_random;
        logic [WIDTH-1:0] a, b, s;
        logic [WIDTH:0] exp;
        logic id, cin, sub, co, rid, to;
        int lat;
        rsp_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            id  = 1'($urandom);
            a   = WIDTH'($urandom);
            b   = WIDTH'($urandom);
            cin = 1'($urandom);
`ifdef ADD_SUB_EN
            sub = 1'($urandom);
`else
            sub = 1'b0;
`endif
            run_op(id, a, b, cin, sub, s, co, rid, lat, to);
            exp = model(a, b, cin, sub);
            n_checks++;
            if (to || s !== exp[WIDTH-1:0] || co !== exp[WIDTH] || rid !== id || lat != NIBS || rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL random_%0d: timeout=%b sum=%h cout=%b id=%b lat=%0d valid_after=%b, required sum=%h cout=%b id=%b lat=%0d valid_after=0",
                         k, to, s, co, rid, lat, rsp_valid, exp[WIDTH-1:0], exp[WIDTH], id, NIBS);
            end
        end
    endtask

`ifdef ADD_SUB_EN
    task automatic test_sub;
        logic [WIDTH-1:0] va[3] = '{16'h0005, 16'h0009, 16'h0005};
        logic [WIDTH-1:0] vb[3] = '{16'h0007, 16'h0003, 16'h0007};
        logic             vc[3] = '{1'b0, 1'b0, 1'b1};
        logic [WIDTH-1:0] es[3] = '{16'hFFFE, 16'h0006, 16'hFFFE};
        logic             ec[3] = '{1'b0, 1'b1, 1'b0};
        logic [WIDTH-1:0] s;
        logic co, rid, to;
        int lat;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_op(1'(k), va[k], vb[k], vc[k], 1'b1, s, co, rid, lat, to);
            n_checks++;
            if (to || s !== es[k] || co !== ec[k]) begin
                n_fail++;
                $display("FAIL sub_%0d: timeout=%b sum=%h cout=%b, required sum=%h cout=%b",
                         k, to, s, co, es[k], ec[k]);
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0; req1_sub = 1'b0;
        rsp_ready = 1'b1;
        test_reset();
        test_directed();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef ADD_SUB_EN
        test_sub();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
